// File: rtl/vga_scan.sv
// -----------------------------------------------------------------------------
// vga_scan
//   Raster side of the VGA pixel interface. It divides the system clock down to
//   the pixel rate, walks the horizontal/vertical counters across the full
//   frame (visible area plus porches and sync), presents the requested row/col
//   to the GPU, and one pixel later drives the sync, enable and colour pins
//   with the GPU's answer. A one-clock frame_end pulse marks the end of the
//   last visible line so sprite state can be updated during vertical blank.
//
// Ports
//   clk        in   1   system clock
//   rst        in   1   synchronous, active-high reset
//   pixel_in   in   12  GPU colour for current row/col: [11:8]=B [7:4]=G [3:0]=R
//   row        out  9   requested line, 0 outside the visible area
//   col        out  10  requested pixel, 0 outside the visible area
//   hs         out  1   horizontal sync, active low
//   vs         out  1   vertical sync, active low
//   rdn        out  1   display enable, active low, aligned with r/g/b
//   r, g, b    out  4   colour to the DAC pins, 0 whenever rdn=1
//   frame_end  out  1   one-clock pulse on the last pixel tick of the last
//                       visible line
// -----------------------------------------------------------------------------
module vga_scan #(
  parameter int DIV     = 4,    // clk cycles per pixel, must be >= 2
  parameter int H_VIS   = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_TOTAL = 800,
  parameter int V_VIS   = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_TOTAL = 525
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] pixel_in,
  output logic [8:0]  row,
  output logic [9:0]  col,
  output logic        hs,
  output logic        vs,
  output logic        rdn,
  output logic [3:0]  r,
  output logic [3:0]  g,
  output logic [3:0]  b,
  output logic        frame_end
);

  localparam int DW = $clog2(DIV);

  localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
  localparam logic [9:0]    H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0]    H_VIS_W   = 10'(H_VIS);
  localparam logic [9:0]    HS_FIRST  = 10'(H_VIS + H_FP);
  localparam logic [9:0]    HS_LAST   = 10'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [9:0]    V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0]    V_VIS_W   = 10'(V_VIS);
  localparam logic [9:0]    V_VIS_END = 10'(V_VIS - 1);
  localparam logic [9:0]    VS_FIRST  = 10'(V_VIS + V_FP);
  localparam logic [9:0]    VS_LAST   = 10'(V_VIS + V_FP + V_SYNC - 1);

  logic [DW-1:0] div_cnt;
  logic [9:0]    h_cnt;
  logic [9:0]    v_cnt;

  logic pix_en;
  logic h_wrap;
  logic v_wrap;
  logic vis;
  logic h_sync_on;
  logic v_sync_on;

  // Pixel tick, wrap points, visibility and sync windows of the current pixel.
  always_comb begin
    pix_en    = (div_cnt == DIV_LAST);
    h_wrap    = (h_cnt == H_LAST);
    v_wrap    = (v_cnt == V_LAST);
    vis       = (h_cnt < H_VIS_W) && (v_cnt < V_VIS_W);
    h_sync_on = (h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST);
    v_sync_on = (v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST);
  end

  // Request side: row/col follow the counters directly so the GPU sees the
  // new coordinate as soon as the counters step; zero while blanking.
  // v_cnt < V_VIS fits in 9 bits, so the low bits are the whole line number.
  always_comb begin
    if (vis) begin
      row = v_cnt[8:0];
      col = h_cnt;
    end else begin
      row = 9'd0;
      col = 10'd0;
    end
  end

  // End-of-visible-frame marker: the tick on which the last visible line's
  // final (blanking) pixel is left behind. Counters are zero in reset, so
  // this is low throughout reset.
  always_comb begin
    frame_end = pix_en && h_wrap && (v_cnt == V_VIS_END);
  end

  // Pixel divider, raster counters and the one-pixel-delayed pin stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      h_cnt   <= 10'd0;
      v_cnt   <= 10'd0;
      hs      <= 1'b1;
      vs      <= 1'b1;
      rdn     <= 1'b1;
      r       <= 4'd0;
      g       <= 4'd0;
      b       <= 4'd0;
    end else begin
      if (pix_en) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + DW'(1);
      end

      if (pix_en) begin
        if (h_wrap) begin
          h_cnt <= 10'd0;
          if (v_wrap) begin
            v_cnt <= 10'd0;
          end else begin
            v_cnt <= v_cnt + 10'd1;
          end
        end else begin
          h_cnt <= h_cnt + 10'd1;
        end

        // Pins reflect the pixel being left; pixel_in has had DIV-1 clocks
        // to settle since row/col changed.
        hs  <= ~h_sync_on;
        vs  <= ~v_sync_on;
        rdn <= ~vis;
        if (vis) begin
          r <= pixel_in[3:0];
          g <= pixel_in[7:4];
          b <= pixel_in[11:8];
        end else begin
          r <= 4'd0;
          g <= 4'd0;
          b <= 4'd0;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_scan.sv
module tb_vga_scan;

  // Reduced raster so several frames fit in a short run; DIV=3 keeps the
  // divider off a power of two.
  localparam int DIV = 3;
  localparam int HV = 40, HF = 4, HS = 8, HT = 60;
  localparam int VV = 6,  VF = 2, VS = 2, VT = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [11:0] pixel_in;
  logic [8:0]  row;
  logic [9:0]  col;
  logic hs, vs, rdn, frame_end;
  logic [3:0] r, g, b;

  int checks = 0;
  int fails  = 0;

  vga_scan #(.DIV(DIV), .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_TOTAL(HT),
             .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_TOTAL(VT)) dut (
    .clk(clk), .rst(rst), .pixel_in(pixel_in), .row(row), .col(col),
    .hs(hs), .vs(vs), .rdn(rdn), .r(r), .g(g), .b(b), .frame_end(frame_end));

  always #5 clk = ~clk;

  // GPU model: registers a coordinate-derived colour one clock after row/col.
  logic [11:0] gpu_q = 12'h000;
  logic force_fff = 1'b0;
  always @(posedge clk) gpu_q <= {col[3:0], row[3:0], col[7:4]};
  assign pixel_in = force_fff ? 12'hfff : gpu_q;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model state: clocks since release, and the colour seen on the last tick.
  int m_e = 0;
  logic [11:0] m_pix = 12'h000;
  logic m_fcap = 1'b0;
  logic armed = 1'b0;
  always @(posedge clk) begin
    armed <= armed | rst;
    if (rst) begin
      m_e <= 0;
    end else begin
      if (m_e % DIV == DIV - 1) begin
        m_pix  <= pixel_in;
        m_fcap <= force_fff;
      end
      m_e <= m_e + 1;
    end
  end

  // Statistics for the directed timing checks.
  int hs_f[2], vs_f[2], rdn_hsf[2], rdn_vsf[2];
  int nhsf, nvsf, hs_r0, vs_r0, nhsr, nvsr, rdn_cnt, nfe, fe0;
  logic prev_hs, prev_vs;

  task automatic clear_stats();
    nhsf = 0; nvsf = 0; nhsr = 0; nvsr = 0; rdn_cnt = 0; nfe = 0;
    fe0 = -1; hs_r0 = -1; vs_r0 = -1;
    hs_f = '{-1, -1}; vs_f = '{-1, -1};
    rdn_hsf = '{0, 0}; rdn_vsf = '{0, 0};
    prev_hs = 1'b1; prev_vs = 1'b1;
  endtask

  // Compare process: every cycle, DUT outputs against the raster model.
  always @(negedge clk) begin
    int n, h, v, p, ph, pv;
    bit vis_now, pvis, e_hs, e_vs, e_fe;
    int er, eg, eb;
    if (armed) begin
      n = m_e / DIV;
      h = n % HT;
      v = (n / HT) % VT;
      vis_now = (h < HV) && (v < VV);
      e_fe = (m_e % DIV == DIV - 1) && (h == HT - 1) && (v == VV - 1);
      chk("row", int'(row), vis_now ? v : 0);
      chk("col", int'(col), vis_now ? h : 0);
      chk("frame_end", int'(frame_end), int'(e_fe));
      if (n == 0) begin
        e_hs = 1'b1; e_vs = 1'b1; pvis = 1'b0; ph = 0; pv = 0;
      end else begin
        p  = n - 1;
        ph = p % HT;
        pv = (p / HT) % VT;
        pvis = (ph < HV) && (pv < VV);
        e_hs = !(ph >= HV + HF && ph < HV + HF + HS);
        e_vs = !(pv >= VV + VF && pv < VV + VF + VS);
      end
      er = pvis ? int'(m_pix[3:0])  : 0;
      eg = pvis ? int'(m_pix[7:4])  : 0;
      eb = pvis ? int'(m_pix[11:8]) : 0;
      chk("hs", int'(hs), int'(e_hs));
      chk("vs", int'(vs), int'(e_vs));
      chk("rdn", int'(rdn), int'(!pvis));
      chk("r", int'(r), er);
      chk("g", int'(g), eg);
      chk("b", int'(b), eb);
      // Pin colour traced back to the previous pixel's coordinates.
      if (pvis && !m_fcap) begin
        chk("b_is_col_lo", int'(b), ph % 16);
        chk("g_is_row_lo", int'(g), pv % 16);
        chk("r_is_col_hi", int'(r), (ph / 16) % 16);
      end
      if (!rst) begin
        if (prev_hs && !hs && nhsf < 2) begin
          hs_f[nhsf] = m_e; rdn_hsf[nhsf] = rdn_cnt; nhsf++;
        end
        if (!prev_hs && hs && nhsf > 0 && nhsr == 0) begin
          hs_r0 = m_e; nhsr = 1;
        end
        if (prev_vs && !vs && nvsf < 2) begin
          vs_f[nvsf] = m_e; rdn_vsf[nvsf] = rdn_cnt; nvsf++;
        end
        if (!prev_vs && vs && nvsf > 0 && nvsr == 0) begin
          vs_r0 = m_e; nvsr = 1;
        end
        if (!rdn) rdn_cnt++;
        if (frame_end) begin
          if (nfe == 0) fe0 = m_e;
          nfe++;
        end
        prev_hs = hs;
        prev_vs = vs;
      end
    end
  end

  task automatic chk_reset_pins(input string tag);
    chk({tag, "_row"}, int'(row), 0);
    chk({tag, "_col"}, int'(col), 0);
    chk({tag, "_hs"}, int'(hs), 1);
    chk({tag, "_vs"}, int'(vs), 1);
    chk({tag, "_rdn"}, int'(rdn), 1);
    chk({tag, "_rgb"}, int'({r, g, b}), 0);
    chk({tag, "_frame_end"}, int'(frame_end), 0);
  endtask

  initial begin
    bit found;
    clear_stats();
    rst = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk_reset_pins("reset");

    @(posedge clk); #1;
    clear_stats();
    rst = 1'b0;
    repeat (2200) @(posedge clk);
    #1 force_fff = 1'b1;
    repeat (1000) @(posedge clk);
    #1 force_fff = 1'b0;
    repeat (2300) @(posedge clk);

    // Hand-computed for DIV=3, 60x12 raster: first hs output of h=44 lands
    // 45 pixels (135 clks) after release; lines are 180 clks; frames 2160.
    chk("hs_first_fall", hs_f[0], 135);
    chk("line_period", hs_f[1] - hs_f[0], 180);
    chk("hs_low_clks", hs_r0 - hs_f[0], 24);
    chk("rdn_low_per_line", rdn_hsf[1] - rdn_hsf[0], 120);
    chk("vs_first_fall", vs_f[0], 1443);
    chk("frame_period", vs_f[1] - vs_f[0], 2160);
    chk("vs_low_clks", vs_r0 - vs_f[0], 360);
    chk("rdn_low_per_frame", rdn_vsf[1] - rdn_vsf[0], 720);
    chk("frame_end_first", fe0, 1079);
    chk("frame_end_count", nfe, 3);

    // Mid-frame reset at row=3, col=20.
    found = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      @(negedge clk);
      if (row == 9'd3 && col == 10'd20) found = 1'b1;
    end
    chk("reach_mid_frame", int'(found), 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_reset_pins("midrst");
    @(posedge clk); #1;
    clear_stats();
    rst = 1'b0;
    repeat (1500) @(posedge clk);
    chk("re_hs_first_fall", hs_f[0], 135);
    chk("re_line_period", hs_f[1] - hs_f[0], 180);
    chk("re_frame_end_first", fe0, 1079);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
